// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB) with bounded MEM wait.
// Optional jal support is compiled in with `define MULTI_CTRL_JAL_EN.
module multi_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_wr,
    output logic [1:0] npc_sel,
    output logic [1:0] ext_op,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       mem_err,
    output logic [2:0] state
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    logic [2:0] state_reg, state_next;
    logic [7:0] wait_cnt_reg;

    logic is_addu, is_subu, is_rtype, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
    logic is_legal;
    logic [1:0] exec_ext;
    logic       exec_src;
    logic [2:0] exec_alu;

    assign is_addu  = (op == 6'h00) && (funct == 6'h21);
    assign is_subu  = (op == 6'h00) && (funct == 6'h23);
    assign is_rtype = is_addu || is_subu;
    assign is_ori   = (op == 6'h0D);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_lui   = (op == 6'h0F);
    assign is_j     = (op == 6'h02);
`ifdef MULTI_CTRL_JAL_EN
    assign is_jal   = (op == 6'h03);
`else
    assign is_jal   = 1'b0;
`endif
    assign is_legal = is_rtype || is_ori || is_lw || is_sw || is_beq || is_lui || is_j || is_jal;

    // Datapath operand/ALU setup, held constant from EXEC through WB.
    always_comb begin
        exec_ext = 2'd0;
        exec_src = 1'b0;
        exec_alu = 3'd0;
        if (is_subu) begin
            exec_alu = 3'd1;
        end else if (is_ori) begin
            exec_src = 1'b1;
            exec_alu = 3'd2;
        end else if (is_lw || is_sw) begin
            exec_ext = 2'd1;
            exec_src = 1'b1;
        end else if (is_lui) begin
            exec_ext = 2'd2;
            exec_src = 1'b1;
            exec_alu = 3'd2;
        end else if (is_beq) begin
            exec_ext = 2'd1;
            exec_alu = 3'd1;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        npc_sel    = 2'd0;
        ext_op     = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 3'd0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        mem_err    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_wr      = 1'b1;
                pc_wr      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'd2;
                end else if (is_jal) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'd2;
                    reg_wr  = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                end else if (is_legal) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                ext_op  = exec_ext;
                alu_src = exec_src;
                alu_op  = exec_alu;
                if (is_beq) begin
                    if (zero) begin
                        pc_wr   = 1'b1;
                        npc_sel = 2'd1;
                    end
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                ext_op  = exec_ext;
                alu_src = exec_src;
                alu_op  = exec_alu;
                mem_wr  = is_sw;
                if (mem_rdy) begin
                    state_next = is_lw ? S_WB : S_FETCH;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    mem_err = 1'b1;
                end else begin
                    state_next = S_MEM;
                end
            end
            S_WB: begin
                ext_op  = exec_ext;
                alu_src = exec_src;
                alu_op  = exec_alu;
                reg_wr  = 1'b1;
                reg_dst = is_rtype ? 2'd1 : 2'd0;
                wd_sel  = is_lw ? 2'd1 : 2'd0;
            end
            default: state_next = S_FETCH;
        endcase
        // Reset silences every strobe immediately, before the state register clears.
        if (rst) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            reg_wr  = 1'b0;
            mem_wr  = 1'b0;
            npc_sel = 2'd0;
            ext_op  = 2'd0;
            alu_src = 1'b0;
            alu_op  = 3'd0;
            reg_dst = 2'd0;
            wd_sel  = 2'd0;
            mem_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg != S_MEM) begin
                wait_cnt_reg <= 8'd0;
            end else if (!mem_rdy) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
        end
    end

    assign state = state_reg;
endmodule

// File: tb/tb_multi_ctrl.sv
// Scoreboard bench for multi_ctrl: per-cycle expected outputs derived from instruction semantics.
module tb_multi_ctrl;
    localparam int MAXW = 15;
`ifdef MULTI_CTRL_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif
    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4,
                   K_BEQ = 5, K_LUI = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic [1:0] npc;
        logic [1:0] ext;
        logic       asrc;
        logic [2:0] aop;
        logic [1:0] rdst;
        logic [1:0] wd;
        logic       err;
    } out_t;

    logic clk, rst, zero, mem_rdy;
    logic [5:0] op, funct;
    logic pc_wr, ir_wr, reg_wr, mem_wr, alu_src, mem_err;
    logic [1:0] npc_sel, ext_op, reg_dst, wd_sel;
    logic [2:0] alu_op, state;

    out_t exq[$];
    int tests = 0;
    int fails = 0;
    int cycle_no = 0;

    multi_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
        .npc_sel(npc_sel), .ext_op(ext_op), .alu_src(alu_src), .alu_op(alu_op),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .mem_err(mem_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle the DUT presents a full output vector; compare against the queue head.
    always @(negedge clk) begin
        out_t e, a;
        cycle_no++;
        if (exq.size() > 0) begin
            e = exq.pop_front();
            a.st = state; a.pc_wr = pc_wr; a.ir_wr = ir_wr; a.reg_wr = reg_wr;
            a.mem_wr = mem_wr; a.npc = npc_sel; a.ext = ext_op; a.asrc = alu_src;
            a.aop = alu_op; a.rdst = reg_dst; a.wd = wd_sel; a.err = mem_err;
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle%0d outputs got=%h exp=%h (st %0d/%0d)",
                         cycle_no, a, e, a.st, e.st);
            end
        end
    end

    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic r, input logic rs, input out_t e);
        op = o; funct = f; zero = z; mem_rdy = r; rst = rs;
        exq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic bit op_is_legal(input logic [5:0] o);
        return (o == 6'h0D) || (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) ||
               (o == 6'h0F) || (o == 6'h02) || (o == 6'h00) || (JAL_EN && o == 6'h03);
    endfunction

    task automatic encode(input int kind, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (kind)
            K_ADDU: begin o = 6'h00; f = 6'h21; end
            K_SUBU: begin o = 6'h00; f = 6'h23; end
            K_ORI:  o = 6'h0D;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2B;
            K_BEQ:  o = 6'h04;
            K_LUI:  o = 6'h0F;
            K_J:    o = 6'h02;
            K_JAL:  o = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = 6'h00;
                    while (f == 6'h21 || f == 6'h23) f = 6'($urandom);
                end else begin
                    o = 6'($urandom);
                    for (int t = 0; t < 64 && op_is_legal(o); t++) o = 6'($urandom);
                    if (op_is_legal(o)) o = 6'h3F;
                end
            end
        endcase
    endtask

    // Operand/ALU selection from the instruction table; constant across EXEC, MEM and WB.
    function automatic out_t alu_cfg(input int kind);
        out_t e = '0;
        case (kind)
            K_SUBU: e.aop = 3'd1;
            K_ORI:  begin e.asrc = 1'b1; e.aop = 3'd2; end
            K_LW, K_SW: begin e.ext = 2'd1; e.asrc = 1'b1; end
            K_LUI:  begin e.ext = 2'd2; e.asrc = 1'b1; e.aop = 3'd2; end
            K_BEQ:  begin e.ext = 2'd1; e.aop = 3'd1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // waits: MEM cycles with mem_rdy low before it rises; rst_at: MEM cycle index to reset in (-1 none).
    task automatic run_instr(input int kind, input logic z, input int waits, input int rst_at);
        logic [5:0] o, f;
        out_t e;
        logic rdy;
        encode(kind, o, f);
        $display("[TB] instr kind=%0d op=%h funct=%h zero=%0d waits=%0d rst_at=%0d",
                 kind, o, f, z, waits, rst_at);
        e = '0; e.st = 3'd0; e.pc_wr = 1'b1; e.ir_wr = 1'b1;
        cyc(o, f, 1'($urandom), 1'($urandom), 1'b0, e);
        e = '0; e.st = 3'd1;
        if (kind == K_J) begin
            e.pc_wr = 1'b1; e.npc = 2'd2;
            cyc(o, f, 1'($urandom), 1'($urandom), 1'b0, e);
            return;
        end
        if (kind == K_JAL && JAL_EN) begin
            e.pc_wr = 1'b1; e.npc = 2'd2; e.reg_wr = 1'b1; e.rdst = 2'd2; e.wd = 2'd2;
            cyc(o, f, 1'($urandom), 1'($urandom), 1'b0, e);
            return;
        end
        cyc(o, f, 1'($urandom), 1'($urandom), 1'b0, e);
        if (kind == K_ILL || kind == K_JAL) return;
        e = alu_cfg(kind); e.st = 3'd2;
        if (kind == K_BEQ) begin
            e.pc_wr = z; e.npc = z ? 2'd1 : 2'd0;
            cyc(o, f, z, 1'($urandom), 1'b0, e);
            return;
        end
        cyc(o, f, 1'($urandom), 1'($urandom), 1'b0, e);
        if (kind == K_LW || kind == K_SW) begin
            for (int k = 0; k < MAXW; k++) begin
                rdy = (k >= waits);
                if (k == rst_at) begin
                    e = '0; e.st = 3'd3;
                    cyc(o, f, 1'($urandom), rdy, 1'b1, e);
                    return;
                end
                e = alu_cfg(kind); e.st = 3'd3; e.mem_wr = (kind == K_SW);
                if (!rdy && k == MAXW - 1) begin
                    e.err = 1'b1;
                    cyc(o, f, 1'($urandom), rdy, 1'b0, e);
                    return;
                end
                cyc(o, f, 1'($urandom), rdy, 1'b0, e);
                if (rdy) break;
            end
            if (kind == K_SW) return;
        end
        e = alu_cfg(kind); e.st = 3'd4; e.reg_wr = 1'b1;
        e.rdst = (kind == K_ADDU || kind == K_SUBU) ? 2'd1 : 2'd0;
        e.wd = (kind == K_LW) ? 2'd1 : 2'd0;
        cyc(o, f, 1'($urandom), 1'($urandom), 1'b0, e);
    endtask

    initial begin
        int kind, w;
        rst = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(6'h23, 6'h00, 1'b1, 1'b1, 1'b1, '0);
        cyc(6'h00, 6'h21, 1'b1, 1'b0, 1'b1, '0);

        run_instr(K_ADDU, 1'b0, 0, -1);
        run_instr(K_BEQ, 1'b1, 0, -1);
        run_instr(K_BEQ, 1'b0, 0, -1);
        run_instr(K_LW, 1'b0, 3, -1);
        run_instr(K_SW, 1'b0, 1000, -1);
        run_instr(K_SW, 1'b0, MAXW - 1, -1);
        run_instr(K_LW, 1'b0, MAXW, -1);
        run_instr(K_JAL, 1'b0, 0, -1);
        run_instr(K_J, 1'b0, 0, -1);
        run_instr(K_ILL, 1'b0, 0, -1);
        run_instr(K_SW, 1'b0, 1000, 2);
        run_instr(K_LUI, 1'b0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0: w = $urandom_range(0, 4);
                1: w = $urandom_range(MAXW - 2, MAXW + 1);
                default: w = $urandom_range(0, MAXW + 3);
            endcase
            run_instr(kind, 1'($urandom), w,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
        end
        run_instr(K_ORI, 1'b0, 0, -1);

        repeat (2) @(negedge clk);
        if (exq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum cycles spent in MEM waiting for mem_rdy before abort (legal range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 op  in  6  opcode field of the instruction register (IR[31:26]).
REQ-005 funct  in  6  function field of the instruction register (IR[5:0]).
REQ-006 zero  in  1  ALU zero flag, valid in EXEC.
REQ-007 mem_rdy  in  1  data-memory completion strobe.
REQ-008 pc_wr, ir_wr, reg_wr, mem_wr  out  1 each  write enables for PC, IR, register file and data memory.
REQ-009 npc_sel  out  2  next-PC source: 0=PC+4, 1=branch target, 2=jump target.
REQ-010 ext_op  out  2  immediate-extender mode: 0=zero-extend, 1=sign-extend, 2=load-upper (imm<<16).
REQ-011 alu_src  out  1  ALU B operand: 0=rt, 1=extended immediate.
REQ-012 alu_op  out  3  0=add, 1=sub, 2=or.
REQ-013 reg_dst  out  2  write register: 0=rt, 1=rd, 2=$31.
REQ-014 wd_sel  out  2  write data: 0=ALU result, 1=memory data, 2=PC (already incremented).
REQ-015 mem_err  out  1  one-cycle pulse on MEM timeout.
REQ-016 state  out  3  current FSM state, for debug.

Function
REQ-017 Supported instructions: addu (op 0, funct 0x21), subu (op 0, funct 0x23), ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, j 0x02, jal 0x03 (see Configuration); anything else is illegal.
REQ-018 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 go to FETCH on the next edge with all enables 0.
REQ-019 Outputs are combinational from the registered state plus op/funct; state is the only register besides the MEM wait counter.
REQ-020 FETCH: ir_wr=1, pc_wr=1, npc_sel=0; next state DECODE.
REQ-021 DECODE, j: pc_wr=1, npc_sel=2; next state FETCH.
REQ-022 DECODE, illegal op or funct: all enables 0; next state FETCH (executes as a nop).
REQ-023 DECODE, all other instructions: all enables 0; next state EXEC.
REQ-024 EXEC drives ext_op, alu_src and alu_op per instruction:
- addu: alu_src=0, alu_op=0
- subu: alu_src=0, alu_op=1
- ori: ext_op=0, alu_src=1, alu_op=2
- lw/sw: ext_op=1, alu_src=1, alu_op=0
- lui: ext_op=2, alu_src=1, alu_op=2 (the datapath ORs with $0)
- beq: ext_op=1, alu_src=0, alu_op=1
REQ-025 ext_op, alu_src and alu_op hold the same EXEC values through MEM and WB.
REQ-026 EXEC transitions: beq goes to FETCH, with pc_wr=1 and npc_sel=1 in EXEC only if zero=1; lw/sw go to MEM; addu/subu/ori/lui go to WB.
REQ-027 MEM, sw: mem_wr=1 in every MEM cycle until exit.
REQ-028 MEM exit on mem_rdy=1: lw goes to WB; sw goes to FETCH.
REQ-029 MEM wait counter: cleared on MEM entry, increments each MEM cycle with mem_rdy=0.
REQ-030 MEM timeout: when the counter reaches MEM_WAIT_MAX with mem_rdy still 0, mem_err=1 for that cycle, next state FETCH, no register write.
REQ-031 mem_rdy=1 in the same cycle the count reaches MEM_WAIT_MAX is a successful completion; mem_err stays 0.
REQ-032 WB: reg_wr=1 for exactly one cycle; next state FETCH.
REQ-033 WB select values: R-type reg_dst=1, wd_sel=0; ori/lui reg_dst=0, wd_sel=0; lw reg_dst=0, wd_sel=1.
REQ-034 mem_rdy outside MEM is ignored.
REQ-035 At most one of pc_wr, reg_wr, mem_wr is asserted per cycle, except FETCH (pc_wr+ir_wr) and JAL decode (REQ-041).

Reset
REQ-036 While rst=1, all write enables, mem_err, npc_sel, ext_op, alu_src, alu_op, reg_dst and wd_sel are 0, overriding the state decode.
REQ-037 On a rising edge with rst=1, state becomes FETCH and the wait counter becomes 0.
REQ-038 Reset asserted mid-instruction (including in MEM with sw pending) aborts it; the first post-reset cycle is FETCH.

Configuration
REQ-039 Macro MULTI_CTRL_JAL_EN compiles jal support in or out.
REQ-040 Without MULTI_CTRL_JAL_EN, op 0x03 is illegal (REQ-022).
REQ-041 With MULTI_CTRL_JAL_EN, DECODE of jal asserts pc_wr=1, npc_sel=2, reg_wr=1, reg_dst=2 and wd_sel=2 in one cycle; next state FETCH.

Verification
REQ-042 Reset then addu: state sequence 0,1,2,4,0; reg_wr=1 only in WB with reg_dst=1.
REQ-043 beq with zero=1 in EXEC: pc_wr=1 and npc_sel=1 in EXEC; with zero=0: no pc_wr; both return to FETCH after 3 cycles.
REQ-044 lw with mem_rdy low for 3 cycles then high: MEM lasts 4 cycles, then WB with wd_sel=1; mem_err never asserted.
REQ-045 sw with mem_rdy held 0 and MEM_WAIT_MAX=15: mem_wr=1 for 15 cycles, mem_err pulses once, next state FETCH.
REQ-046 op 0x03 in both builds: without the macro, nop in 2 cycles; with it, 2-cycle execution with pc_wr=reg_wr=1, reg_dst=2, wd_sel=2.
REQ-047 rst raised in MEM during sw: mem_wr drops in the same cycle; state is 0 after the next edge.
